// File: rtl/flash_arbiter_pkg.sv
// Shared types and constants for the two-master flash arbiter.
package flash_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGnt0 = 2'd1,
        StGnt1 = 2'd2,
        StErr  = 2'd3
    } state_e;

    // Level of wb_rst_i that takes reset.
    localparam logic RstActive = 1'b0;

endpackage

// File: rtl/flash_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes to
// the master that was not granted last.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic       valid_o,
    output logic       gnt_o
);

    always_comb begin
        valid_o = |req_i;
        gnt_o   = 1'b0;
        case (req_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = ~last_gnt_i;
            default: gnt_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/flash_arbiter.sv
// Two-master Wishbone arbiter for the shared read-only flash port: round-robin
// grant held until ack, local write rejection and a per-access watchdog.
module flash_arbiter
    import flash_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 32,
    parameter int unsigned TW      = 6
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,

    output logic        busy_o
);

    localparam logic [TW-1:0] CntLast = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic          err_sel_q, err_sel_d;

    logic [1:0]  req;
    logic        arb_valid;
    logic        arb_gnt;
    logic        win_we;

    logic        gnt_sel;
    logic        g_cyc;
    logic        g_stb;
    logic [31:0] g_adr;
    logic [3:0]  g_sel;
    logic        timeout;

    logic [1:0]  ack_v;
    logic [1:0]  err_v;

    // Write data has nowhere to go on a read-only slave.
    logic        unused_wdat;
    assign unused_wdat = ^{m0_dat_i, m1_dat_i};

    assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    rr_arb2 u_rr_arb2 (
        .req_i      (req),
        .last_gnt_i (last_gnt_q),
        .valid_o    (arb_valid),
        .gnt_o      (arb_gnt)
    );

    assign win_we  = arb_gnt ? m1_we_i : m0_we_i;

    assign gnt_sel = (state_q == StGnt1);
    assign g_cyc   = gnt_sel ? m1_cyc_i : m0_cyc_i;
    assign g_stb   = gnt_sel ? m1_stb_i : m0_stb_i;
    assign g_adr   = gnt_sel ? m1_adr_i : m0_adr_i;
    assign g_sel   = gnt_sel ? m1_sel_i : m0_sel_i;
    assign timeout = (cnt_q == CntLast);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_gnt_d = last_gnt_q;
        err_sel_d  = err_sel_q;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_dat_o    = '0;
        s_sel_o    = '0;
        ack_v      = 2'b00;
        err_v      = 2'b00;

        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    if (win_we) begin
                        state_d   = StErr;
                        err_sel_d = arb_gnt;
                    end else begin
                        state_d    = arb_gnt ? StGnt1 : StGnt0;
                        cnt_d      = '0;
                        last_gnt_d = arb_gnt;
                    end
                end
            end

            StGnt0, StGnt1: begin
                // The watchdog cycle pulls the slave off the bus; an ack in that
                // same cycle still completes the access normally.
                s_cyc_o = g_cyc & ~timeout;
                s_stb_o = g_stb & ~timeout;
                s_adr_o = g_adr;
                s_sel_o = g_sel;
                cnt_d   = cnt_q + TW'(1);
                ack_v   = gnt_sel ? {s_ack_i, 1'b0} : {1'b0, s_ack_i};
                err_v   = gnt_sel ? {timeout & ~s_ack_i, 1'b0} : {1'b0, timeout & ~s_ack_i};
                if (s_ack_i || !g_cyc || timeout) begin
                    state_d = StIdle;
                end
            end

            StErr: begin
                err_v   = err_sel_q ? 2'b10 : 2'b01;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i == RstActive) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_gnt_q <= 1'b1;
            err_sel_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_gnt_q <= last_gnt_d;
            err_sel_q  <= err_sel_d;
        end
    end

    assign m0_ack_o = ack_v[0];
    assign m0_err_o = err_v[0];
    assign m0_dat_o = (state_q == StGnt0) ? s_dat_i : '0;
    assign m1_ack_o = ack_v[1];
    assign m1_err_o = err_v[1];
    assign m1_dat_o = (state_q == StGnt1) ? s_dat_i : '0;
    assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_flash_arbiter.sv
// Randomized and directed bench for flash_arbiter with a queue-based scoreboard
// and a latency-programmable flash slave model.
module tb_flash_arbiter;

    localparam int unsigned TIMEOUT = 32;
    localparam int unsigned NRAND   = 80;

    typedef struct {
        bit          err;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        m_cyc  [2];
    logic        m_stb  [2];
    logic        m_we   [2];
    logic [31:0] m_adr  [2];
    logic [31:0] m_wdat [2];
    logic [3:0]  m_sel  [2];

    logic [31:0] m0_dat, m1_dat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we, s_ack, busy;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        q0[$];
    exp_t        q1[$];

    // Slave: acks in cycle L of a continuous cyc&stb burst, L from address bits
    // [7:2] unless overridden. L above TIMEOUT means it effectively never acks.
    int unsigned lat_ovr = 0;
    int unsigned sl_cnt = 0;
    logic        sl_ack = 1'b0;

    function automatic int unsigned lat_of(input logic [31:0] a);
        return (lat_ovr != 0) ? lat_ovr : int'(a[7:2]);
    endfunction

    function automatic logic [31:0] dat_of(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : ({a[15:0], a[31:16]} ^ 32'h3C3C_A5A5);
    endfunction

    assign s_rdat = dat_of(s_adr);
    assign s_ack  = sl_ack;

    always @(posedge clk) begin
        if (!(s_cyc && s_stb) || sl_ack) begin
            sl_cnt <= 0;
            sl_ack <= 1'b0;
        end else begin
            sl_cnt <= sl_cnt + 1;
            sl_ack <= (sl_cnt + 2 == lat_of(s_adr));
        end
    end

    flash_arbiter #(
        .TIMEOUT (TIMEOUT),
        .TW      (6)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .m0_cyc_i (m_cyc[0]),
        .m0_stb_i (m_stb[0]),
        .m0_we_i  (m_we[0]),
        .m0_adr_i (m_adr[0]),
        .m0_dat_i (m_wdat[0]),
        .m0_sel_i (m_sel[0]),
        .m0_dat_o (m0_dat),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m1_cyc_i (m_cyc[1]),
        .m1_stb_i (m_stb[1]),
        .m1_we_i  (m_we[1]),
        .m1_adr_i (m_adr[1]),
        .m1_dat_i (m_wdat[1]),
        .m1_sel_i (m_sel[1]),
        .m1_dat_o (m1_dat),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_wdat),
        .s_sel_o  (s_sel),
        .s_dat_i  (s_rdat),
        .s_ack_i  (s_ack),
        .busy_o   (busy)
    );

    function automatic logic ack_of(input int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 0) ? m0_err : m1_err;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic push_exp(input int m, input bit err, input logic [31:0] dat);
        exp_t e;
        e.err = err;
        e.dat = dat;
        if (m == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic drive(input int m, input bit cyc, input bit we, input logic [31:0] adr);
        m_cyc[m]  = cyc;
        m_stb[m]  = cyc;
        m_we[m]   = we;
        m_adr[m]  = adr;
        m_wdat[m] = $urandom;
        m_sel[m]  = 4'hF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every ack/err strobe consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            vectors++;
            if (s_we !== 1'b0 || s_wdat !== 32'h0) begin
                miscompares++;
                $display("FAIL slave_write: got we=%b dat=%h, expected 0", s_we, s_wdat);
            end
            if ((m0_ack || m0_err) && (m1_ack || m1_err || m1_dat != 0)) begin
                vectors++;
                miscompares++;
                $display("FAIL exclusive: m1 ack=%b err=%b dat=%h while m0 responds, expected 0",
                         m1_ack, m1_err, m1_dat);
            end
            if (m0_ack || m0_err) begin
                vectors++;
                if (q0.size() == 0) begin
                    miscompares++;
                    $display("FAIL m0_resp: got ack=%b err=%b, expected no response", m0_ack,
                             m0_err);
                end else begin
                    e = q0.pop_front();
                    if (m0_err !== e.err || m0_ack === m0_err || (!e.err && m0_dat !== e.dat)) begin
                        miscompares++;
                        $display("FAIL m0_resp: got ack=%b err=%b dat=%h, expected err=%b dat=%h",
                                 m0_ack, m0_err, m0_dat, e.err, e.dat);
                    end
                end
            end
            if (m1_ack || m1_err) begin
                vectors++;
                if (q1.size() == 0) begin
                    miscompares++;
                    $display("FAIL m1_resp: got ack=%b err=%b, expected no response", m1_ack,
                             m1_err);
                end else begin
                    e = q1.pop_front();
                    if (m1_err !== e.err || m1_ack === m1_err || (!e.err && m1_dat !== e.dat)) begin
                        miscompares++;
                        $display("FAIL m1_resp: got ack=%b err=%b dat=%h, expected err=%b dat=%h",
                                 m1_ack, m1_err, m1_dat, e.err, e.dat);
                    end
                end
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_ctl"}, {24'h0, s_cyc, s_stb, s_we, busy, m0_ack, m0_err, m1_ack, m1_err},
            32'h0);
        chk({name, "_sadr"}, s_adr, 32'h0);
        chk({name, "_ssel"}, {28'h0, s_sel}, 32'h0);
        chk({name, "_m0dat"}, m0_dat, 32'h0);
        chk({name, "_m1dat"}, m1_dat, 32'h0);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) drive(i, 1'b0, 1'b0, 32'h0);
        repeat (2) step();
        @(negedge clk);
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
    endtask

    // m0 reads 0x10, slave answers in grant cycle 13.
    task automatic single_read();
        lat_ovr = 13;
        drive(0, 1'b1, 1'b0, 32'h10);
        push_exp(0, 1'b0, 32'hDEAD_BEEF);
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            chk1("rd_ack", m0_ack, k == 13);
            chk1("rd_scyc", s_cyc, k >= 1 && k <= 13);
            chk("rd_m1", m1_dat | {30'h0, m1_ack, m1_err}, 32'h0);
            step();
            if (k == 13) drive(0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    // Both masters request together; 'first' is the master that must win.
    task automatic contend(input int first);
        int          second;
        logic [31:0] a[2];
        second  = 1 - first;
        lat_ovr = 3;
        for (int i = 0; i < 2; i++) begin
            a[i] = $urandom & 32'hFFFF_FFFC;
            drive(i, 1'b1, 1'b0, a[i]);
            push_exp(i, 1'b0, dat_of(a[i]));
        end
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            chk1("cont_ack_first", ack_of(first), k == 3);
            chk1("cont_ack_second", ack_of(second), k == 7);
            chk1("cont_busy", busy, k != 0 && k != 4 && k != 8);
            if (k == 1) chk("cont_adr_first", s_adr, a[first]);
            if (k == 5) chk("cont_adr_second", s_adr, a[second]);
            step();
            if (k == 3) drive(first, 1'b0, 1'b0, 32'h0);
            if (k == 7) drive(second, 1'b0, 1'b0, 32'h0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int          issued[2];
        bit          pend[2];
        int          gap[2];
        int          age[2];
        bit          seen[2];
        int          budget;
        logic [31:0] r;
        logic [31:0] adr;
        logic [5:0]  lat;
        bit          we;
        logic [31:0] a0, a1;

        reset_dut();
        contend(0);
        contend(0);
        single_read();
        contend(1);

        // Write rejection on m1.
        drive(1, 1'b1, 1'b1, 32'h100);
        m_wdat[1] = 32'h1234;
        push_exp(1, 1'b1, 32'h0);
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk1("wr_err", m1_err, k == 1);
            chk1("wr_ack", m1_ack, 1'b0);
            chk1("wr_scyc", s_cyc, 1'b0);
            chk1("wr_busy", busy, k == 1);
            step();
            if (k == 1) drive(1, 1'b0, 1'b0, 32'h0);
        end

        // Slave never answers: watchdog fires in grant cycle 32.
        lat_ovr = 63;
        drive(0, 1'b1, 1'b0, 32'h0000_4000);
        push_exp(0, 1'b1, 32'h0);
        for (int k = 0; k <= 34; k++) begin
            @(negedge clk);
            chk1("to_err", m0_err, k == 32);
            chk1("to_scyc", s_cyc, k >= 1 && k <= 31);
            chk1("to_busy", busy, k >= 1 && k <= 32);
            step();
            if (k == 32) drive(0, 1'b0, 1'b0, 32'h0);
        end

        // Ack in the watchdog cycle completes normally.
        lat_ovr = TIMEOUT;
        drive(0, 1'b1, 1'b0, 32'h0000_5000);
        push_exp(0, 1'b0, dat_of(32'h0000_5000));
        for (int k = 0; k <= 33; k++) begin
            @(negedge clk);
            chk1("tie_ack", m0_ack, k == 32);
            chk1("tie_err", m0_err, 1'b0);
            step();
            if (k == 32) drive(0, 1'b0, 1'b0, 32'h0);
        end

        // m1 aborts in grant cycle 5 while m0 waits.
        lat_ovr = 20;
        a0 = 32'h0000_6100;
        a1 = 32'h0000_7200;
        drive(1, 1'b1, 1'b0, a1);
        push_exp(0, 1'b0, dat_of(a0));
        for (int k = 0; k <= 27; k++) begin
            @(negedge clk);
            chk1("ab_m1_ack", m1_ack, 1'b0);
            chk1("ab_m0_ack", m0_ack, k == 26);
            if (k == 5) chk1("ab_scyc_drop", s_cyc, 1'b0);
            if (k == 6) chk1("ab_idle_gap", busy, 1'b0);
            if (k == 7) chk("ab_m0_adr", s_adr, a0);
            step();
            if (k == 0) drive(0, 1'b1, 1'b0, a0);
            if (k == 4) drive(1, 1'b0, 1'b0, 32'h0);
            if (k == 26) drive(0, 1'b0, 1'b0, 32'h0);
        end

        // Reset during GNT0, then a tie must go to m0 again.
        lat_ovr = 20;
        drive(0, 1'b1, 1'b0, 32'h0000_8000);
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k == 3) chk1("mr_granted", s_cyc, 1'b1);
            if (k == 4) chk_all_zero("midrst");
            step();
            if (k == 2) rst_n = 1'b0;
            if (k == 4) begin
                rst_n = 1'b1;
                drive(0, 1'b0, 1'b0, 32'h0);
            end
        end
        contend(0);

        // Randomized traffic from both masters.
        lat_ovr = 0;
        for (int i = 0; i < 2; i++) begin
            issued[i] = 0;
            pend[i]   = 1'b0;
            gap[i]    = 0;
            age[i]    = 0;
        end
        budget = 0;
        while ((issued[0] < NRAND || issued[1] < NRAND || pend[0] || pend[1]) && budget < 30000) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) seen[i] = ack_of(i) || err_of(i);
            step();
            budget++;
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    age[i]++;
                    if (seen[i]) begin
                        pend[i] = 1'b0;
                        drive(i, 1'b0, 1'b0, 32'h0);
                        gap[i] = $urandom_range(0, 3);
                    end else if (age[i] > 200) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rand_m%0d_stuck: no response after %0d cycles, expected one",
                                 i, age[i]);
                        pend[i] = 1'b0;
                        drive(i, 1'b0, 1'b0, 32'h0);
                    end
                end else if (gap[i] > 0) begin
                    gap[i]--;
                end else if (issued[i] < NRAND) begin
                    r   = $urandom;
                    lat = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(2, 40))
                                                      : 6'($urandom_range(2, 8));
                    we  = ($urandom_range(0, 5) == 0);
                    adr = {r[31:8], lat, 2'b00};
                    drive(i, 1'b1, we, adr);
                    push_exp(i, we || (lat > 6'(TIMEOUT)), dat_of(adr));
                    pend[i] = 1'b1;
                    age[i]  = 0;
                    issued[i]++;
                end
            end
        end
        chk("rand_budget", {31'h0, budget >= 30000}, 32'h0);
        repeat (4) step();
        chk("q0_drained", q0.size(), 32'h0);
        chk("q1_drained", q1.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
